id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
RV32I instruction-decode pipeline stage; sits between fetch and execute and drives the register file's read ports.
- Accepts an instruction/PC pair from fetch through a valid/ready handshake.
- Decodes fields, generates the immediate, and reads rs1/rs2 from the register file.
- Registers everything into the ID/EX pipeline register.
- Detects load-use hazards and inserts bubbles; honours flush from branch resolution.

Parameters:
XLEN, 32, datapath width.
RESET_PC, 32'h0000_0000, value of ex_pc after reset.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
if_valid  in  1  fetch presents an instruction
if_ready  out  1  ID consumes the instruction this cycle
if_pc  in  XLEN  PC of the fetched instruction
if_instr  in  32  instruction word
rf_raddr1  out  5  register-file read address 1 (= if_instr[19:15])
rf_raddr2  out  5  register-file read address 2 (= if_instr[24:20])
rf_rdata1  in  XLEN  combinational read data 1
rf_rdata2  in  XLEN  combinational read data 2
flush  in  1  kill the instruction in ID and in the ID/EX register
ex_ready  in  1  execute accepts the ID/EX contents
ex_valid  out  1  ID/EX holds a real instruction
ex_pc  out  XLEN  instruction PC
ex_rs1_data, ex_rs2_data  out  XLEN  operand values
ex_rs1, ex_rs2, ex_rd  out  5 each  register indices
ex_imm  out  XLEN  sign-extended immediate
ex_alu_op  out  4  alu_op_e code
ex_alu_src_imm  out  1  operand B = imm
ex_alu_src_pc  out  1  operand A = pc (AUIPC, JAL)
ex_funct3  out  3  branch condition / memory size
ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_jalr, ex_illegal  out  1 each  control flags

Behaviour:
- Reset (rst=1 at posedge):
  - ex_valid=0, ex_pc=RESET_PC.
  - All other ex_* outputs are 0.
  - rst has priority over flush and the handshake.
  - Reset mid-stall drops the held instruction.
- rf_raddr1/2 are combinational from if_instr; no gating.
- x0 handling: the register file does not hardwire x0. ID forces operand data to 0 whenever rs1 (resp. rs2) is 0, regardless of rf_rdata.
- Register file reads are valid in the same cycle as the posedge. The register file writes on the falling edge, so WB-to-ID needs no forwarding here.
- Load-use hazard: hazard = if_valid & ex_valid & ex_mem_read & ex_rd≠0 & (ex_rd==rs1 | ex_rd==rs2). rs2 is compared only for OP, STORE and BRANCH formats.
- advance = ex_ready | ~ex_valid.
- if_ready = advance & ~hazard. When flush=1, if_ready = 1 (the instruction is discarded).
- Register update priority at posedge, first match wins:
  1. rst.
  2. flush: ex_valid←0.
  3. ~advance: hold all ex_* outputs.
  4. hazard: ex_valid←0 (bubble); control flags cleared.
  5. if_valid: load the decoded instruction, ex_valid←1.
  6. Otherwise ex_valid←0.
- Latency: 1 cycle from acceptance to ex_valid. Throughput 1/cycle absent hazards. A load-use costs exactly one bubble.
- Decode by opcode:
  - LUI: U-immediate, PASS_B, src_imm.
  - AUIPC: U-immediate, ADD, src_pc, src_imm.
  - JAL: J-immediate, jump, reg_write.
  - JALR: I-immediate, jump, jalr, reg_write.
  - BRANCH: B-immediate, branch, reg_write=0.
  - LOAD: I-immediate, ADD, mem_read.
  - STORE: S-immediate, ADD, mem_write.
  - OP-IMM: I-immediate; funct3 selects the op; SRAI when instr[30]=1.
  - OP: funct3/funct7 select the op; SUB/SRA when instr[30]=1.
  - MISC-MEM (FENCE): NOP, no flags.
- Illegal instruction, which covers:
  - any other opcode;
  - SYSTEM;
  - instr[1:0]≠11;
  - OP with funct7 ∉ {0, 0x20} or an invalid pairing;
  - OP-IMM shifts with illegal imm[11:5].
  
  Response: ex_illegal=1 and reg_write/mem_read/mem_write/branch/jump=0.
- reg_write is cleared when rd=0.
- Immediates are sign-extended from instr[31]. B and J immediates have bit 0 = 0.

Decomposition:
- Package rv32i_pkg:
  - opcode localparams: OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_MISCMEM, OPC_SYSTEM;
  - alu_op_e: ADD=0, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B;
  - id_ex_t struct bundling the ex_* fields.
- Sub-module id_decoder: purely combinational instr → control flags plus immediate. id_stage keeps the hazard logic, handshake, x0 masking and the ID/EX register.

Test Plan:
- addi x5,x0,7 (0x00700293), rf_rdata1=0xDEADBEEF, ex_ready=1 → next cycle ex_valid=1, ex_rs1_data=0, ex_imm=7, ex_alu_op=ADD, ex_alu_src_imm=1, ex_rd=5, ex_reg_write=1.
- lw x6,0(x5) (0x0002A303) then add x7,x6,x6 (0x006303B3) back-to-back:
  - cycle 2: if_ready=0, ex_valid=0 (bubble);
  - cycle 3: add in ID/EX with ex_rs1=ex_rs2=6.
  - Repeat with add x7,x0,x0 → no bubble.
- beq x1,x2,-8 (0xFE208CE3) → ex_imm=0xFFFFFFF8, ex_branch=1, ex_reg_write=0, ex_funct3=0.
- Back-pressure: ex_ready=0 for 3 cycles with the instruction in ID/EX and if_valid=1 → all ex_* stable, if_ready=0. On release, the next instruction appears one cycle later with nothing lost or duplicated.
- flush=1 while if_valid=1 and ex_valid=1 → next cycle ex_valid=0, if_ready=1, the instruction is never presented. flush during a hazard stall → bubble, the stalled instruction is discarded.
- 0xFFFFFFFF, then 0x00000073 (ECALL) → ex_illegal=1, all write/memory flags 0. Assert rst mid-stream → next cycle ex_valid=0, ex_pc=RESET_PC.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes and the ID/EX
// pipeline register layout.
package rv32i_pkg;

  localparam int unsigned RV_XLEN = 32;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic [RV_XLEN-1:0] imm;
    alu_op_e            alu_op;
    logic               alu_src_imm;
    logic               alu_src_pc;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               branch;
    logic               jump;
    logic               jalr;
    logic               illegal;
    logic               uses_rs2;
  } dec_ctrl_t;

  typedef struct packed {
    logic               valid;
    logic [RV_XLEN-1:0] pc;
    logic [RV_XLEN-1:0] rs1_data;
    logic [RV_XLEN-1:0] rs2_data;
    logic [RV_XLEN-1:0] imm;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    alu_op_e            alu_op;
    logic               alu_src_imm;
    logic               alu_src_pc;
    logic [2:0]         funct3;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               branch;
    logic               jump;
    logic               jalr;
    logic               illegal;
  } id_ex_t;

  // Shared by OP and OP-IMM; alt picks SUB/SRA where instr[30] selects them.
  function automatic alu_op_e f3_to_alu(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch, register-file and execute signals seen by the decode stage.
interface id_stage_if #(parameter int unsigned XLEN = 32);
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic [4:0]      rf_raddr1;
  logic [4:0]      rf_raddr2;
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;
  logic            flush;
  logic            ex_ready;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_imm;
  logic [3:0]      ex_alu_op;
  logic            ex_alu_src_imm;
  logic            ex_alu_src_pc;
  logic [2:0]      ex_funct3;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_reg_write;
  logic            ex_branch;
  logic            ex_jump;
  logic            ex_jalr;
  logic            ex_illegal;

  modport master (
    output if_valid, if_pc, if_instr, rf_rdata1, rf_rdata2, flush, ex_ready,
    input  if_ready, rf_raddr1, rf_raddr2, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
           ex_rs1, ex_rs2, ex_rd, ex_imm, ex_alu_op, ex_alu_src_imm, ex_alu_src_pc,
           ex_funct3, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump,
           ex_jalr, ex_illegal
  );

  modport slave (
    input  if_valid, if_pc, if_instr, rf_rdata1, rf_rdata2, flush, ex_ready,
    output if_ready, rf_raddr1, rf_raddr2, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
           ex_rs1, ex_rs2, ex_rd, ex_imm, ex_alu_op, ex_alu_src_imm, ex_alu_src_pc,
           ex_funct3, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump,
           ex_jalr, ex_illegal
  );
endinterface

// File: rtl/id_decoder.sv
// Combinational RV32I decoder: instruction word to control flags and
// sign-extended immediate.
module id_decoder
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output dec_ctrl_t   ctrl
);

  logic [6:0]  opcode_s;
  logic [6:0]  funct7_s;
  logic [2:0]  funct3_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_u_s;
  logic [31:0] imm_j_s;
  logic        legal_s;
  dec_ctrl_t   raw_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];

  assign imm_i_s = {{20{instr[31]}}, instr[31:20]};
  assign imm_s_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u_s = {instr[31:12], 12'h000};
  assign imm_j_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Opcode decode; funct-field legality is resolved in the same pass.
  always_comb begin
    raw_s        = '0;
    raw_s.alu_op = ALU_ADD;
    legal_s      = 1'b1;
    case (opcode_s)
      OPC_LUI: begin
        raw_s.imm         = imm_u_s;
        raw_s.alu_op      = ALU_PASS_B;
        raw_s.alu_src_imm = 1'b1;
        raw_s.reg_write   = 1'b1;
      end
      OPC_AUIPC: begin
        raw_s.imm         = imm_u_s;
        raw_s.alu_src_pc  = 1'b1;
        raw_s.alu_src_imm = 1'b1;
        raw_s.reg_write   = 1'b1;
      end
      OPC_JAL: begin
        raw_s.imm         = imm_j_s;
        raw_s.alu_src_pc  = 1'b1;
        raw_s.alu_src_imm = 1'b1;
        raw_s.jump        = 1'b1;
        raw_s.reg_write   = 1'b1;
      end
      OPC_JALR: begin
        raw_s.imm         = imm_i_s;
        raw_s.alu_src_imm = 1'b1;
        raw_s.jump        = 1'b1;
        raw_s.jalr        = 1'b1;
        raw_s.reg_write   = 1'b1;
      end
      OPC_BRANCH: begin
        raw_s.imm      = imm_b_s;
        raw_s.alu_op   = ALU_SUB;
        raw_s.branch   = 1'b1;
        raw_s.uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        raw_s.imm         = imm_i_s;
        raw_s.alu_src_imm = 1'b1;
        raw_s.mem_read    = 1'b1;
        raw_s.reg_write   = 1'b1;
      end
      OPC_STORE: begin
        raw_s.imm         = imm_s_s;
        raw_s.alu_src_imm = 1'b1;
        raw_s.mem_write   = 1'b1;
        raw_s.uses_rs2    = 1'b1;
      end
      OPC_OPIMM: begin
        raw_s.imm         = imm_i_s;
        raw_s.alu_src_imm = 1'b1;
        raw_s.reg_write   = 1'b1;
        raw_s.alu_op      = f3_to_alu(funct3_s, (funct3_s == 3'b101) & instr[30]);
        case (funct3_s)
          3'b001:  legal_s = (funct7_s == 7'h00);
          3'b101:  legal_s = (funct7_s == 7'h00) | (funct7_s == 7'h20);
          default: legal_s = 1'b1;
        endcase
      end
      OPC_OP: begin
        raw_s.reg_write = 1'b1;
        raw_s.uses_rs2  = 1'b1;
        raw_s.alu_op    = f3_to_alu(funct3_s, instr[30]);
        case (funct7_s)
          7'h00:   legal_s = 1'b1;
          7'h20:   legal_s = (funct3_s == 3'b000) | (funct3_s == 3'b101);
          default: legal_s = 1'b0;
        endcase
      end
      OPC_MISCMEM: legal_s = 1'b1;
      OPC_SYSTEM:  legal_s = 1'b0;
      default:     legal_s = 1'b0;
    endcase
  end

  // Illegal encodings keep only the format bit that the hazard check needs.
  always_comb begin
    ctrl = raw_s;
    if (!legal_s) begin
      ctrl          = '0;
      ctrl.alu_op   = ALU_ADD;
      ctrl.illegal  = 1'b1;
      ctrl.uses_rs2 = raw_s.uses_rs2;
    end else begin
      ctrl.illegal = 1'b0;
    end
    ctrl.reg_write = ctrl.reg_write & (instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: fetch handshake, register-file read with x0 masking,
// load-use stall and the ID/EX pipeline register.
module id_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);

  dec_ctrl_t  dec_s;
  id_ex_t     ex_r;
  id_ex_t     ex_nxt_s;
  id_ex_t     load_s;
  id_ex_t     reset_ex_s;
  logic [4:0] rs1_s;
  logic [4:0] rs2_s;
  logic       hazard_s;
  logic       advance_s;

  id_decoder u_decoder (
    .instr (bus.if_instr),
    .ctrl  (dec_s)
  );

  assign rs1_s         = bus.if_instr[19:15];
  assign rs2_s         = bus.if_instr[24:20];
  assign bus.rf_raddr1 = rs1_s;
  assign bus.rf_raddr2 = rs2_s;

  assign hazard_s  = bus.if_valid & ex_r.valid & ex_r.mem_read & (ex_r.rd != 5'd0) &
                     ((ex_r.rd == rs1_s) | (dec_s.uses_rs2 & (ex_r.rd == rs2_s)));
  assign advance_s = bus.ex_ready | ~ex_r.valid;
  // A flushed instruction is taken so fetch can move on; it is simply dropped.
  assign bus.if_ready = bus.flush | (advance_s & ~hazard_s);

  // Decoded instruction as it would enter ID/EX; x0 reads are forced to zero.
  always_comb begin
    load_s             = '0;
    load_s.valid       = 1'b1;
    load_s.pc          = bus.if_pc;
    load_s.rs1_data    = (rs1_s == 5'd0) ? 32'h0000_0000 : bus.rf_rdata1;
    load_s.rs2_data    = (rs2_s == 5'd0) ? 32'h0000_0000 : bus.rf_rdata2;
    load_s.imm         = dec_s.imm;
    load_s.rs1         = rs1_s;
    load_s.rs2         = rs2_s;
    load_s.rd          = bus.if_instr[11:7];
    load_s.alu_op      = dec_s.alu_op;
    load_s.alu_src_imm = dec_s.alu_src_imm;
    load_s.alu_src_pc  = dec_s.alu_src_pc;
    load_s.funct3      = bus.if_instr[14:12];
    load_s.mem_read    = dec_s.mem_read;
    load_s.mem_write   = dec_s.mem_write;
    load_s.reg_write   = dec_s.reg_write;
    load_s.branch      = dec_s.branch;
    load_s.jump        = dec_s.jump;
    load_s.jalr        = dec_s.jalr;
    load_s.illegal     = dec_s.illegal;
  end

  // Reset image of the pipeline register.
  always_comb begin
    reset_ex_s    = '0;
    reset_ex_s.pc = RESET_PC;
  end

  // Next ID/EX contents: flush, then stall, then bubble, then load.
  always_comb begin
    ex_nxt_s = ex_r;
    if (bus.flush) begin
      ex_nxt_s.valid = 1'b0;
    end else if (!advance_s) begin
      ex_nxt_s = ex_r;
    end else if (hazard_s) begin
      ex_nxt_s.valid     = 1'b0;
      ex_nxt_s.mem_read  = 1'b0;
      ex_nxt_s.mem_write = 1'b0;
      ex_nxt_s.reg_write = 1'b0;
      ex_nxt_s.branch    = 1'b0;
      ex_nxt_s.jump      = 1'b0;
      ex_nxt_s.jalr      = 1'b0;
      ex_nxt_s.illegal   = 1'b0;
    end else if (bus.if_valid) begin
      ex_nxt_s = load_s;
    end else begin
      ex_nxt_s.valid = 1'b0;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r <= reset_ex_s;
    end else begin
      ex_r <= ex_nxt_s;
    end
  end

  assign bus.ex_valid       = ex_r.valid;
  assign bus.ex_pc          = ex_r.pc;
  assign bus.ex_rs1_data    = ex_r.rs1_data;
  assign bus.ex_rs2_data    = ex_r.rs2_data;
  assign bus.ex_rs1         = ex_r.rs1;
  assign bus.ex_rs2         = ex_r.rs2;
  assign bus.ex_rd          = ex_r.rd;
  assign bus.ex_imm         = ex_r.imm;
  assign bus.ex_alu_op      = ex_r.alu_op;
  assign bus.ex_alu_src_imm = ex_r.alu_src_imm;
  assign bus.ex_alu_src_pc  = ex_r.alu_src_pc;
  assign bus.ex_funct3      = ex_r.funct3;
  assign bus.ex_mem_read    = ex_r.mem_read;
  assign bus.ex_mem_write   = ex_r.mem_write;
  assign bus.ex_reg_write   = ex_r.reg_write;
  assign bus.ex_branch      = ex_r.branch;
  assign bus.ex_jump        = ex_r.jump;
  assign bus.ex_jalr        = ex_r.jalr;
  assign bus.ex_illegal     = ex_r.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios then randomized traffic, all checked
// against an instruction-level reference model of the decode stage.
module tb_id_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int A_ADD = 0, A_SUB = 1, A_SLL = 2, A_SLT = 3, A_SLTU = 4, A_XOR = 5;
  localparam int A_SRL = 6, A_SRA = 7, A_OR = 8, A_AND = 9, A_PASSB = 10;

  typedef struct {
    bit        valid;
    bit [31:0] pc, rs1_data, rs2_data, imm;
    bit [4:0]  rs1, rs2, rd;
    int        alu;
    bit        src_imm, src_pc;
    bit [2:0]  f3;
    bit        mem_read, mem_write, reg_write, branch, jump, jalr, illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] regs [32];
  exp_t        m;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  id_stage_if #(.XLEN(32)) bus ();

  id_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.rf_rdata1 = regs[bus.rf_raddr1];
  assign bus.rf_rdata2 = regs[bus.rf_raddr2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic bit [31:0] sra(input bit [31:0] x, input int n);
    logic signed [31:0] s;
    s = x;
    return 32'(s >>> n);
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e    = '{default: 0};
    e.pc = RESET_PC;
    return e;
  endfunction

  // Reference decode straight from the ISA field layout.
  function automatic exp_t ref_decode(input bit [31:0] pc, input bit [31:0] ins);
    exp_t     e;
    bit [6:0] f7;
    bit       legal;
    int       base_op [8];
    base_op = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    e = '{default: 0};
    f7 = ins[31:25];
    legal = 1'b1;
    e.valid = 1'b1; e.pc = pc; e.f3 = ins[14:12];
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.rs1_data = (e.rs1 == 5'd0) ? 32'd0 : regs[e.rs1];
    e.rs2_data = (e.rs2 == 5'd0) ? 32'd0 : regs[e.rs2];
    case (ins[6:0])
      7'h37: begin e.imm = ins & 32'hFFFFF000; e.alu = A_PASSB; e.src_imm = 1; e.reg_write = 1; end
      7'h17: begin e.imm = ins & 32'hFFFFF000; e.src_pc = 1; e.src_imm = 1; e.reg_write = 1; end
      7'h6F: begin
        e.imm = sra(ins & 32'h80000000, 11) | (ins & 32'h000FF000) |
                ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7FE);
        e.src_pc = 1; e.src_imm = 1; e.jump = 1; e.reg_write = 1;
      end
      7'h67: begin e.imm = sra(ins, 20); e.src_imm = 1; e.jump = 1; e.jalr = 1; e.reg_write = 1; end
      7'h63: begin
        e.imm = sra(ins & 32'h80000000, 19) | ((ins << 4) & 32'h800) |
                ((ins >> 20) & 32'h7E0) | ((ins >> 7) & 32'h1E);
        e.alu = A_SUB; e.branch = 1;
      end
      7'h03: begin e.imm = sra(ins, 20); e.src_imm = 1; e.mem_read = 1; e.reg_write = 1; end
      7'h23: begin
        e.imm = sra(ins & 32'hFE000000, 20) | ((ins >> 7) & 32'h1F);
        e.src_imm = 1; e.mem_write = 1;
      end
      7'h13: begin
        e.imm = sra(ins, 20); e.src_imm = 1; e.reg_write = 1; e.alu = base_op[e.f3];
        if (e.f3 == 3'd1) legal = (f7 == 7'h00);
        if (e.f3 == 3'd5) begin
          legal = (f7 == 7'h00) || (f7 == 7'h20);
          if (f7 == 7'h20) e.alu = A_SRA;
        end
      end
      7'h33: begin
        e.reg_write = 1; e.alu = base_op[e.f3];
        if (f7 == 7'h20) begin
          if (e.f3 == 3'd0) e.alu = A_SUB;
          else if (e.f3 == 3'd5) e.alu = A_SRA;
          else legal = 0;
        end else if (f7 != 7'h00) legal = 0;
      end
      7'h0F: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.imm = 0; e.alu = A_ADD; e.src_imm = 0; e.src_pc = 0;
      e.mem_read = 0; e.mem_write = 0; e.reg_write = 0; e.branch = 0;
      e.jump = 0; e.jalr = 0; e.illegal = 1;
    end
    if (e.rd == 5'd0) e.reg_write = 0;
    return e;
  endfunction

  task automatic cmp_ex();
    check_val("ex_valid", 32'(bus.ex_valid), 32'(m.valid));
    check_val("ex_pc", bus.ex_pc, m.pc);
    check_val("ex_rs1_data", bus.ex_rs1_data, m.rs1_data);
    check_val("ex_rs2_data", bus.ex_rs2_data, m.rs2_data);
    check_val("ex_imm", bus.ex_imm, m.imm);
    check_val("ex_rs1", 32'(bus.ex_rs1), 32'(m.rs1));
    check_val("ex_rs2", 32'(bus.ex_rs2), 32'(m.rs2));
    check_val("ex_rd", 32'(bus.ex_rd), 32'(m.rd));
    check_val("ex_alu_op", 32'(bus.ex_alu_op), 32'(m.alu));
    check_val("ex_src_imm", 32'(bus.ex_alu_src_imm), 32'(m.src_imm));
    check_val("ex_src_pc", 32'(bus.ex_alu_src_pc), 32'(m.src_pc));
    check_val("ex_funct3", 32'(bus.ex_funct3), 32'(m.f3));
    check_val("ex_mem_read", 32'(bus.ex_mem_read), 32'(m.mem_read));
    check_val("ex_mem_write", 32'(bus.ex_mem_write), 32'(m.mem_write));
    check_val("ex_reg_write", 32'(bus.ex_reg_write), 32'(m.reg_write));
    check_val("ex_branch", 32'(bus.ex_branch), 32'(m.branch));
    check_val("ex_jump", 32'(bus.ex_jump), 32'(m.jump));
    check_val("ex_jalr", 32'(bus.ex_jalr), 32'(m.jalr));
    check_val("ex_illegal", 32'(bus.ex_illegal), 32'(m.illegal));
  endtask

  // One clock: drive at negedge, check handshake, advance model, check ID/EX.
  task automatic cycle(input bit iv, input bit [31:0] pc, input bit [31:0] ins,
                       input bit fl, input bit er, input bit r, output bit rdy);
    exp_t d;
    bit   haz, adv, u2;
    @(negedge clk);
    bus.if_valid = iv; bus.if_pc = pc; bus.if_instr = ins;
    bus.flush = fl; bus.ex_ready = er; rst = r;
    #1;
    u2  = (ins[6:0] == 7'h33) || (ins[6:0] == 7'h23) || (ins[6:0] == 7'h63);
    haz = iv && m.valid && m.mem_read && (m.rd != 5'd0) &&
          ((m.rd == ins[19:15]) || (u2 && (m.rd == ins[24:20])));
    adv = er || !m.valid;
    rdy = fl || (adv && !haz);
    if (!r) check_val("if_ready", 32'(bus.if_ready), 32'(rdy));
    check_val("rf_raddr1", 32'(bus.rf_raddr1), 32'(ins[19:15]));
    check_val("rf_raddr2", 32'(bus.rf_raddr2), 32'(ins[24:20]));
    d = ref_decode(pc, ins);
    if (r) m = reset_exp();
    else if (fl) m.valid = 0;
    else if (adv) begin
      if (haz) begin
        m.valid = 0; m.mem_read = 0; m.mem_write = 0; m.reg_write = 0;
        m.branch = 0; m.jump = 0; m.jalr = 0; m.illegal = 0;
      end else if (iv) m = d;
      else m.valid = 0;
    end
    @(posedge clk);
    #1;
    cmp_ex();
  endtask

  function automatic bit [31:0] rand_instr();
    bit [31:0] w;
    bit [6:0]  opcs [11];
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    w = $urandom;
    w[6:0]   = opcs[$urandom_range(0, 10)];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 0) w[31:25] = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 3) == 0) w[6:0] = 7'h03;
    if ($urandom_range(0, 15) == 0) w = $urandom;
    return w;
  endfunction

  initial begin
    bit        rdy, iv, hold, fl, er, r;
    bit [31:0] pc, ins;
    foreach (regs[i]) regs[i] = $urandom;
    m = reset_exp();
    rst = 1'b1; bus.if_valid = 1'b0; bus.if_pc = 32'd0; bus.if_instr = 32'd0;
    bus.flush = 1'b0; bus.ex_ready = 1'b1;

    cycle(0, 32'h0, 32'h0, 0, 1, 1, rdy);
    check_val("rst_valid", 32'(bus.ex_valid), 32'd0);
    check_val("rst_pc", bus.ex_pc, RESET_PC);

    regs[0] = 32'hDEADBEEF;
    cycle(1, 32'h200, 32'h00700293, 0, 1, 0, rdy);
    check_val("addi_rs1d", bus.ex_rs1_data, 32'd0);
    check_val("addi_imm", bus.ex_imm, 32'd7);
    check_val("addi_alu", 32'(bus.ex_alu_op), 32'd0);
    check_val("addi_rd", 32'(bus.ex_rd), 32'd5);
    check_val("addi_rw", 32'(bus.ex_reg_write), 32'd1);

    cycle(1, 32'h204, 32'h0002A303, 0, 1, 0, rdy);
    cycle(1, 32'h208, 32'h006303B3, 0, 1, 0, rdy);
    check_val("lu_ready", 32'(rdy), 32'd0);
    check_val("lu_bubble", 32'(bus.ex_valid), 32'd0);
    cycle(1, 32'h208, 32'h006303B3, 0, 1, 0, rdy);
    check_val("lu_rs1", 32'(bus.ex_rs1), 32'd6);
    check_val("lu_rs2", 32'(bus.ex_rs2), 32'd6);
    cycle(1, 32'h20C, 32'h0002A303, 0, 1, 0, rdy);
    cycle(1, 32'h210, 32'h000003B3, 0, 1, 0, rdy);
    check_val("nohaz_pc", bus.ex_pc, 32'h210);

    cycle(1, 32'h214, 32'hFE208CE3, 0, 1, 0, rdy);
    check_val("beq_imm", bus.ex_imm, 32'hFFFFFFF8);
    check_val("beq_br", 32'(bus.ex_branch), 32'd1);
    check_val("beq_rw", 32'(bus.ex_reg_write), 32'd0);

    cycle(1, 32'h218, 32'h00100093, 0, 1, 0, rdy);
    for (int i = 0; i < 3; i++) cycle(1, 32'h21C, 32'h00208133, 0, 0, 0, rdy);
    check_val("bp_hold_pc", bus.ex_pc, 32'h218);
    cycle(1, 32'h21C, 32'h00208133, 0, 1, 0, rdy);
    check_val("bp_release_pc", bus.ex_pc, 32'h21C);

    cycle(1, 32'h220, 32'h00100093, 0, 1, 0, rdy);
    cycle(1, 32'h224, 32'h00200113, 1, 0, 0, rdy);
    check_val("flush_valid", 32'(bus.ex_valid), 32'd0);
    cycle(1, 32'h228, 32'h0002A303, 0, 1, 0, rdy);
    cycle(1, 32'h22C, 32'h006303B3, 1, 1, 0, rdy);
    check_val("flush_haz_valid", 32'(bus.ex_valid), 32'd0);
    cycle(1, 32'h230, 32'h00100093, 0, 1, 0, rdy);
    check_val("after_flush_pc", bus.ex_pc, 32'h230);

    cycle(1, 32'h234, 32'hFFFFFFFF, 0, 1, 0, rdy);
    check_val("ill_ffff", 32'(bus.ex_illegal), 32'd1);
    cycle(1, 32'h238, 32'h00000073, 0, 1, 0, rdy);
    check_val("ill_ecall", 32'(bus.ex_illegal), 32'd1);
    cycle(1, 32'h23C, 32'h00100093, 0, 1, 1, rdy);
    check_val("midrst_valid", 32'(bus.ex_valid), 32'd0);
    check_val("midrst_pc", bus.ex_pc, RESET_PC);

    // Random traffic; fetch holds an unaccepted instruction until taken or flushed.
    pc = 32'h1000; ins = 32'h0; iv = 0; hold = 0;
    for (int n = 0; n < 2000; n++) begin
      fl = ($urandom_range(0, 24) == 0);
      r  = ($urandom_range(0, 99) == 0);
      er = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        iv  = ($urandom_range(0, 4) != 0);
        pc  = pc + 32'd4;
        ins = rand_instr();
      end
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 7)] = $urandom;
      cycle(iv, pc, ins, fl, er, r, rdy);
      hold = iv && !rdy && !fl && !r;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
